// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if: request, response and ALU-side signals of the shared-ALU arbiter
interface alu_rr_arbiter_if #(
    parameter int DW  = 4,
    parameter int OPW = 3,
    parameter int RW  = 8
);
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0] req0_op, req1_op;
    logic [DW-1:0]  alu_a, alu_b;
    logic [OPW-1:0] alu_op;
    logic [RW-1:0]  alu_result;
    logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [RW-1:0]  rsp0_data, rsp1_data;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_op,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_op,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_rr_arbiter #(
    parameter int DW  = 4,
    parameter int OPW = 3,
    parameter int RW  = 8
) (
    input logic              clk,
    input logic              rst_n,
    alu_rr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d, owner_q, owner_d;
    logic           v0_q, v0_d, v1_q, v1_d;
    logic [DW-1:0]  a_q, a_d, b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic [RW-1:0]  d0_q, d0_d, d1_q, d1_d;
    logic           gnt0, gnt1;

    // grant only in IDLE; on contention the requester that did not win last time goes first
    always_comb begin
        gnt0 = rst_n && state_q == IDLE && bus.req0_valid && (!bus.req1_valid || last_q);
        gnt1 = rst_n && state_q == IDLE && bus.req1_valid && (!bus.req0_valid || !last_q);
    end

    // next-state: latch operands on accept, capture ALU result after EXEC, release on response handshake
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        if (gnt0 || gnt1) begin
            state_d = EXEC;
            owner_d = gnt1;
            last_d  = gnt1;
            a_d     = gnt1 ? bus.req1_a  : bus.req0_a;
            b_d     = gnt1 ? bus.req1_b  : bus.req0_b;
            op_d    = gnt1 ? bus.req1_op : bus.req0_op;
        end
        if (state_q == EXEC) begin
            state_d = RESP;
            v0_d    = !owner_q;
            v1_d    = owner_q;
            d0_d    = owner_q ? d0_q : bus.alu_result;
            d1_d    = owner_q ? bus.alu_result : d1_q;
        end
        if (state_q == RESP && (owner_q ? bus.rsp1_ready : bus.rsp0_ready)) begin
            state_d = IDLE;
            v0_d    = 1'b0;
            v1_d    = 1'b0;
        end
    end

    // state and output registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.rsp0_valid = v0_q;
    assign bus.rsp1_valid = v1_q;
    assign bus.rsp0_data  = d0_q;
    assign bus.rsp1_data  = d1_q;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed checks of arbitration, latency, backpressure and reset
module tb_alu_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu_rr_arbiter_if #(.DW(4), .OPW(3), .RW(8)) bus();
    alu_rr_arbiter #(.DW(4), .OPW(3), .RW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    assign bus.alu_result = {bus.alu_a, bus.alu_b} ^ {5'b0, bus.alu_op};

    always #5 clk = ~clk;

    logic [10:0] p0 [5] = '{{4'h1,4'h2,3'd0}, {4'h2,4'h3,3'd1}, {4'h4,4'h5,3'd2}, {4'h6,4'h7,3'd3}, {4'h8,4'h9,3'd4}};
    logic [10:0] p1 [5] = '{{4'h3,4'h4,3'd7}, {4'hA,4'hB,3'd5}, {4'hC,4'hD,3'd6}, {4'hE,4'hF,3'd1}, {4'h0,4'hF,3'd7}};
    logic [7:0]  x0 [5] = '{8'h12, 8'h22, 8'h47, 8'h64, 8'h8D};
    logic [7:0]  x1 [5] = '{8'h33, 8'hAE, 8'hCB, 8'hEE, 8'h08};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp0_valid, bus.rsp1_valid,
                  bus.rsp0_data, bus.rsp1_data, bus.req0_ready, bus.req1_ready}, 0);
    endtask

    task automatic run_pair();
        int i0 = 0, i1 = 0, r0 = 0, r1 = 0, g = 0, nr = 0, cyc = 0;
        int last_acc = 0, ac0 = 0, ac1 = 0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        while (nr < 10 && cyc < 100) begin
            bus.req0_valid = i0 < 5;
            bus.req1_valid = i1 < 5;
            {bus.req0_a, bus.req0_b, bus.req0_op} = p0[i0 < 5 ? i0 : 0];
            {bus.req1_a, bus.req1_b, bus.req1_op} = p1[i1 < 5 ? i1 : 0];
            #1;
            chk("ready_excl", bus.req0_ready & bus.req1_ready, 0);
            if (bus.req0_ready || bus.req1_ready) begin
                chk("grant_order", bus.req1_ready, g % 2);
                if (g > 0) chk("issue_gap", cyc - last_acc, 3);
                last_acc = cyc;
                g++;
                if (bus.req1_ready) begin ac1 = cyc; i1++; end
                else begin ac0 = cyc; i0++; end
            end
            if (bus.rsp0_valid) begin
                if (r0 < 5) chk("rsp0_data", bus.rsp0_data, x0[r0]);
                else chk("rsp0_extra", 1, 0);
                chk("rsp0_lat", cyc - ac0, 2);
                chk("rsp0_excl", bus.rsp1_valid, 0);
                r0++;
                nr++;
            end else if (bus.rsp1_valid) begin
                if (r1 < 5) chk("rsp1_data", bus.rsp1_data, x1[r1]);
                else chk("rsp1_extra", 1, 0);
                chk("rsp1_lat", cyc - ac1, 2);
                r1++;
                nr++;
            end
            tick();
            cyc++;
        end
        chk("pair_done", nr, 10);
        chk("pair_grants", g, 10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        {bus.req0_a, bus.req0_b, bus.req0_op} = '0;
        {bus.req1_a, bus.req1_b, bus.req1_op} = '0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        #12;
        chk_zero("reset_outs");
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // simultaneous start then continuous contention
        run_pair();

        // single request from requester 0
        bus.req0_valid = 1'b1;
        {bus.req0_a, bus.req0_b, bus.req0_op} = {4'h5, 4'h9, 3'd3};
        #1;
        chk("t1_ready0", bus.req0_ready, 1);
        chk("t1_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t1_alu_a", bus.alu_a, 4'h5);
        chk("t1_alu_op", bus.alu_op, 3);
        chk("t1_exec_v", bus.rsp0_valid, 0);
        tick();
        chk("t1_rsp0_v", bus.rsp0_valid, 1);
        chk("t1_rsp0_d", bus.rsp0_data, 8'h5A);
        chk("t1_rsp1_v", bus.rsp1_valid, 0);
        tick();
        chk("t1_rsp0_drop", bus.rsp0_valid, 0);
        chk("t1_rsp0_hold", bus.rsp0_data, 8'h5A);
        chk("t1_alu_b_hold", bus.alu_b, 4'h9);

        // backpressure on requester 1 while requester 0 waits
        bus.rsp1_ready = 1'b0;
        bus.req1_valid = 1'b1;
        {bus.req1_a, bus.req1_b, bus.req1_op} = {4'h5, 4'h9, 3'd2};
        #1;
        chk("bp_ready1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        {bus.req0_a, bus.req0_b, bus.req0_op} = {4'h7, 4'h1, 3'd0};
        #1;
        chk("bp_exec_ready0", bus.req0_ready, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp1_v", bus.rsp1_valid, 1);
            chk("bp_rsp1_d", bus.rsp1_data, 8'h5B);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_rsp0_v", bus.rsp0_valid, 0);
            tick();
        end
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_hs_ready0", bus.req0_ready, 0);
        tick();
        chk("bp_rsp1_drop", bus.rsp1_valid, 0);
        chk("bp_rsp1_hold", bus.rsp1_data, 8'h5B);
        chk("bp_accept0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        chk("bp_rsp0_d", bus.rsp0_data, 8'h71);
        chk("bp_rsp0_v", bus.rsp0_valid, 1);
        tick();

        // reset while an operation is in EXEC
        bus.req1_valid = 1'b1;
        {bus.req1_a, bus.req1_b, bus.req1_op} = {4'h3, 4'h3, 3'd1};
        #1;
        chk("mr_ready1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        #1;
        chk("mr_alu_a", bus.alu_a, 4'h3);
        rst_n = 1'b0;
        #1;
        chk_zero("mr_outs");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("mr_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
            tick();
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        {bus.req0_a, bus.req0_b, bus.req0_op} = {4'h2, 4'h2, 3'd2};
        #1;
        chk("mr_first0", bus.req0_ready, 1);
        chk("mr_first1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk("mr_rsp0_d", bus.rsp0_data, 8'h20);
        chk("mr_rsp1_v", bus.rsp1_valid, 0);
        tick();

        // opcode sweep on requester 1
        for (int op = 0; op < 8; op++) begin
            bus.req1_valid = 1'b1;
            bus.req1_a = 4'b0101;
            bus.req1_b = 4'b1001;
            bus.req1_op = 3'(op);
            #1;
            chk("sw_ready", bus.req1_ready, 1);
            tick();
            bus.req1_valid = 1'b0;
            #1;
            chk("sw_op", bus.alu_op, op);
            tick();
            chk("sw_v", bus.rsp1_valid, 1);
            chk("sw_data", bus.rsp1_data, 32'h59 ^ op);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
